// File: rtl/sdram_cache.sv
// Direct-mapped, write-through one-byte-per-line cache between the AVR CPU bus
// and the SDRAM controller's level-request / ce handshake.
module sdram_cache #(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 27
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [7:0]        cpu_in,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [7:0]        cpu_out,
    output logic              cpu_ce,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [7:0]        mem_out,
    input  logic              mem_ce
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [7:0]       data_mem [LINES];
    logic [7:0]       fill;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] mem_idx;
    logic [TAG_W-1:0] mem_tag;
    logic             hit;
    logic             done;

    assign idx      = cpu_address[IDX_W-1:0];
    assign addr_tag = cpu_address[ADDR_W-1:IDX_W];
    assign mem_idx  = mem_address[IDX_W-1:0];
    assign mem_tag  = mem_address[ADDR_W-1:IDX_W];
    assign hit      = valid[idx] && (tag_mem[idx] == addr_tag);
    assign done     = (state == S_WAIT) && mem_ce;

    always_comb begin
        cpu_ce = 1'b0;
        case (state)
            S_IDLE:  cpu_ce = !cpu_write && !(cpu_read && !hit);
            S_DONE:  cpu_ce = 1'b1;
            default: cpu_ce = 1'b0;
        endcase
    end

    // Unfilled lines read as zero so cpu_out is defined straight out of reset.
    assign cpu_out = (state == S_DONE) ? fill : (hit ? data_mem[idx] : 8'h00);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            valid       <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_in      <= 8'h00;
            fill        <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush)
                        valid <= '0;
                    if (cpu_write) begin
                        mem_address <= cpu_address;
                        mem_in      <= cpu_in;
                        mem_write   <= 1'b1;
                        state       <= S_REQ;
                    end else if (cpu_read && !hit) begin
                        mem_address <= cpu_address;
                        mem_read    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!mem_ce)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    // Request stays up until the controller reports idle again.
                    if (mem_ce) begin
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        valid[mem_idx] <= 1'b1;
                        if (!mem_write)
                            fill <= mem_out;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk_in) begin
        if (done) begin
            tag_mem[mem_idx]  <= mem_tag;
            data_mem[mem_idx] <= mem_write ? mem_in : mem_out;
        end
    end

endmodule

// File: tb/tb_sdram_cache.sv
// Bench for sdram_cache: randomized CPU traffic against a line-map reference
// model, with a behavioural SDRAM controller on the memory side.
module tb_sdram_cache;

    localparam int IDX_W  = 6;
    localparam int ADDR_W = 27;
    localparam int LINES  = 1 << IDX_W;
    localparam int BOUND  = 60;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              flush;
    logic [ADDR_W-1:0] cpu_address;
    logic [7:0]        cpu_in;
    logic              cpu_read;
    logic              cpu_write;
    logic [7:0]        cpu_out;
    logic              cpu_ce;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_in;
    logic              mem_read;
    logic              mem_write;
    logic [7:0]        mem_out;
    logic              mem_ce;

    sdram_cache #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .flush       (flush),
        .cpu_address (cpu_address),
        .cpu_in      (cpu_in),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_out     (cpu_out),
        .cpu_ce      (cpu_ce),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_out     (mem_out),
        .mem_ce      (mem_ce)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37 + 11) ^ (a >> 8));
    endfunction

    // Controller-side storage (written from what the DUT drives) and CPU-side reference.
    logic [7:0] sdram   [int];
    logic [7:0] ref_mem [int];
    int         line_addr [LINES];

    function automatic logic [7:0] sdram_get(input int a);
        return sdram.exists(a) ? sdram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_get(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic void invalidate_all();
        for (int i = 0; i < LINES; i++) line_addr[i] = -1;
    endfunction

    // Behavioural SDRAM controller: accepts a level request, drops mem_ce while busy.
    int         rd_done    = 0;
    int         wr_done    = 0;
    int         last_addr  = -1;
    int         force_busy = 0;
    int         c_addr;
    int         c_busy;
    logic       c_wr;
    logic [7:0] c_data;

    initial begin
        mem_ce  = 1'b1;
        mem_out = 8'h00;
        forever begin
            @(posedge clk_in); #1;
            if (mem_read || mem_write) begin
                c_addr = int'(mem_address);
                c_wr   = mem_write;
                c_data = mem_in;
                repeat ($urandom_range(0, 2)) @(posedge clk_in);
                #1;
                mem_ce = 1'b0;
                c_busy = (force_busy > 0) ? force_busy : int'($urandom_range(1, 3));
                repeat (c_busy) @(posedge clk_in);
                #1;
                if (c_wr) sdram[c_addr] = c_data;
                else      mem_out = sdram_get(c_addr);
                mem_ce    = 1'b1;
                last_addr = c_addr;
                if (c_wr) wr_done++;
                else      rd_done++;
                while (mem_read || mem_write) begin
                    @(posedge clk_in); #1;
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        int k = 0;
        while (!cpu_ce && k < BOUND) begin
            @(negedge clk_in);
            k++;
        end
        chk(tag, 32'(k < BOUND), 32'(1));
    endtask

    task automatic do_read(input int a);
        int         i   = a % LINES;
        int         rd0 = rd_done;
        int         wr0 = wr_done;
        logic       exp_hit;
        logic [7:0] exp_d;
        exp_hit     = (line_addr[i] == a);
        exp_d       = ref_get(a);
        cpu_address = a[ADDR_W-1:0];
        cpu_read    = 1'b1;
        cpu_write   = 1'b0;
        @(negedge clk_in);
        if (exp_hit) begin
            chk("hit_ce", 32'(cpu_ce), 32'(1));
            chk("hit_data", 32'(cpu_out), 32'(exp_d));
            chk("hit_no_mem_read", 32'(mem_read), 32'(0));
        end else begin
            chk("miss_ce_low", 32'(cpu_ce), 32'(0));
            wait_done("miss_timeout");
            chk("miss_data", 32'(cpu_out), 32'(exp_d));
            chk("miss_addr", 32'(last_addr), 32'(a));
            line_addr[i] = a;
        end
        @(posedge clk_in); #1;
        cpu_read = 1'b0;
        chk("rd_mem_reads", 32'(rd_done), 32'(exp_hit ? rd0 : rd0 + 1));
        chk("rd_mem_writes", 32'(wr_done), 32'(wr0));
    endtask

    task automatic do_write(input int a, input logic [7:0] d, input logic both);
        int i   = a % LINES;
        int rd0 = rd_done;
        int wr0 = wr_done;
        cpu_address = a[ADDR_W-1:0];
        cpu_in      = d;
        cpu_write   = 1'b1;
        cpu_read    = both;
        @(negedge clk_in);
        chk("wr_ce_low", 32'(cpu_ce), 32'(0));
        wait_done("wr_timeout");
        @(posedge clk_in); #1;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
        chk("wr_mem_writes", 32'(wr_done), 32'(wr0 + 1));
        chk("wr_no_mem_read", 32'(rd_done), 32'(rd0));
        chk("wr_addr", 32'(last_addr), 32'(a));
        chk("wr_sdram_data", 32'(sdram_get(a)), 32'(d));
        ref_mem[a]   = d;
        line_addr[i] = a;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk_in); #1;
        flush = 1'b0;
        invalidate_all();
    endtask

    int k;
    int r;
    int a;

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        cpu_address = '0;
        cpu_in      = 8'h00;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        invalidate_all();
        sdram[32'h40]   = 8'h5A;
        ref_mem[32'h40] = 8'h5A;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_mem_read", 32'(mem_read), 32'(0));
        chk("rst_mem_write", 32'(mem_write), 32'(0));
        chk("rst_mem_address", 32'(mem_address), 32'(0));
        chk("rst_mem_in", 32'(mem_in), 32'(0));
        chk("rst_cpu_out", 32'(cpu_out), 32'(0));
        chk("rst_cpu_ce", 32'(cpu_ce), 32'(1));
        reset = 1'b0;
        @(posedge clk_in); #1;

        // Directed scenarios: miss, hit, write, conflict, flush.
        do_read(32'h40);
        chk("first_fill_data", 32'(ref_get(32'h40)), 32'h5A);
        do_read(32'h40);
        do_write(32'h40, 8'hC3, 1'b0);
        do_read(32'h40);
        do_read(32'h80);
        do_read(32'h40);
        do_flush();
        do_read(32'h80);

        // Reset while the controller is mid-transaction on a read miss.
        force_busy  = 6;
        cpu_address = 27'h1C0;
        cpu_read    = 1'b1;
        k = 0;
        while (mem_ce && k < BOUND) begin
            @(negedge clk_in);
            k++;
        end
        chk("rst_wait_accept", 32'(k < BOUND), 32'(1));
        @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_req_held", 32'(mem_read), 32'(1));
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_read", 32'(mem_read), 32'(0));
        chk("rst_mid_cpu_ce", 32'(cpu_ce), 32'(0));
        cpu_read = 1'b0;
        invalidate_all();
        @(negedge clk_in);
        reset = 1'b0;
        k = 0;
        while (!mem_ce && k < BOUND) begin
            @(negedge clk_in);
            k++;
        end
        chk("rst_ctrl_finish", 32'(k < BOUND), 32'(1));
        force_busy = 0;
        repeat (2) @(posedge clk_in);
        #1;
        do_read(32'h40);

        do_write(32'h10, 8'hA5, 1'b1);
        do_read(32'h10);

        // Randomized traffic over a few tags sharing a handful of lines.
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            a = (int'($urandom_range(0, 3)) << IDX_W) | int'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = a | (1 << (ADDR_W - 1));
            if (r < 55)      do_read(a);
            else if (r < 85) do_write(a, 8'($urandom), 1'b0);
            else if (r < 92) do_write(a, 8'($urandom), 1'b1);
            else             do_flush();
            repeat ($urandom_range(0, 2)) @(posedge clk_in);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
